servo_pwm_gen: RTL
==================

Name: servo_pwm_gen

Overview:
- Downstream consumer of the angle decoder's 20-bit PWM constant `value`.
- Turns `value` into a glitch-free servo PWM waveform: one frame per 20 ms, with a high time of `width` clock cycles.
- Clamps the commanded width and, optionally, slew-limits it per frame so the servo never jumps.
- Drives the PmodCON3 servo pin directly; default frame is 20 ms at 100 MHz.

Parameters:
- PERIOD_CYCLES, 2000000, frame length in clk cycles (20 ms at 100 MHz).
- CNT_W, 21, frame counter width; must satisfy 2^CNT_W >= PERIOD_CYCLES.
- MIN_PULSE, 20'd25000, lower clamp on pulse width (cycles).
- MAX_PULSE, 20'd260000, upper clamp on pulse width; must be < PERIOD_CYCLES.
- RESET_PULSE, 20'd150000, width loaded at reset (servo neutral / stop).
- SLEW_STEP, 20'd5000, maximum width change per frame; 0 disables slew limiting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  output enable; sampled only at the frame boundary
- value  in  20  commanded pulse width in cycles (from the angle decoder); sampled only at the frame boundary
- pwm_out  out  1  registered servo PWM
- frame_start  out  1  one-cycle pulse in the first cycle of each frame
- cur_width  out  20  pulse width applied in the current frame
- settled  out  1  high when cur_width equals the clamped target

Behaviour:
- Interface (already decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low. All state is registered on the rising edge of clk.
- Reset values: cnt=0, cur_width=RESET_PULSE, en_q=0, pwm_out=0, frame_start=0, settled=0. Asserting reset mid-pulse forces pwm_out low immediately.
- Frame counter: cnt runs 0..PERIOD_CYCLES-1 and wraps to 0. It runs continuously, regardless of en.
- frame_start is registered and equals 1 in the cycle after cnt==0 is reached. It is aligned with the first high cycle of pwm_out.
- Boundary update: in the cycle where cnt==PERIOD_CYCLES-1, the block samples en and value and updates the following:
  - en_q <= en.
  - tgt = clamp(value, MIN_PULSE, MAX_PULSE), unsigned compare.
  - If SLEW_STEP==0: cur_width <= tgt.
  - Else if |tgt-cur_width| <= SLEW_STEP: cur_width <= tgt.
  - Else: cur_width <= cur_width ± SLEW_STEP, moving toward tgt. Use a 21-bit difference; no wrap is allowed.
  - settled <= (next cur_width == tgt).
- Values that change between boundaries are ignored. The width never changes mid-frame.
- Output: pwm_out <= en_q && (cnt < cur_width), registered, so there is 1 cycle of latency from cnt. Each enabled frame carries exactly cur_width high cycles, starting at the frame start.
- en deasserted mid-frame: the current pulse completes untruncated, and the next frame is fully low.
- en low: pwm_out stays low, the counter and slew tracking continue, and frame_start keeps pulsing.
- First frame after reset: en_q=0, so the frame is low. Output can start no earlier than the second frame.
- value=0 or value>MAX_PULSE: clamped. The block never produces a 0-width or full-frame pulse.

Decomposition:
- Shared package `servo_pkg`:
  - typedef pulse_t = logic [19:0].
  - Constants SERVO_PERIOD_100MHZ=2000000, SERVO_NEUTRAL=150000, SERVO_MIN=25000, SERVO_MAX=260000.
- Sub-module `servo_slew_limiter` (combinational): inputs cur, tgt_raw, step; outputs clamped tgt, next_width, settled_next. It is unit-testable on its own.
- Counter, enable latch and output register stay in servo_pwm_gen.

Test Plan (bench override: PERIOD_CYCLES=1000, CNT_W=10, MIN_PULSE=50, MAX_PULSE=900, RESET_PULSE=500, SLEW_STEP=100):
- Reset release with en=1, value=500: frame 1 fully low; frame 2 onward pwm_out high exactly 500 cycles per 1000; settled=1; frame_start every 1000 cycles.
- Slew: value steps 500->800 while en=1: cur_width goes 600, 700, 800 over three frames; settled=0 until it reaches 800, then settled=1.
- Clamp: value=0 -> cur_width settles at 50. value=20'hFFFFF -> cur_width settles at 900, and pwm_out still drops low for 100 cycles each frame.
- Mid-frame changes: with cur_width=500, toggle value to 300 at cnt=200 and drop en at cnt=250. Current pulse stays 500 cycles; next frame fully low; cur_width becomes 400.
- Async reset at cnt=100 during the pulse: pwm_out low in the same cycle, before the next clk edge. After release, cur_width=500 and cnt restarts at 0.
- SLEW_STEP=0 build: value 100->900 is applied in the next frame in one step; settled=1 right after the boundary.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo PWM path.
// Widths are in clk cycles; the 100 MHz defaults give a 20 ms frame.
package servo_pkg;

    typedef logic [19:0] pulse_t;

    localparam int unsigned SERVO_PERIOD_100MHZ = 2000000;
    localparam pulse_t      SERVO_NEUTRAL       = 20'd150000;
    localparam pulse_t      SERVO_MIN           = 20'd25000;
    localparam pulse_t      SERVO_MAX           = 20'd260000;

    function automatic pulse_t clamp_pulse(input pulse_t v, input pulse_t lo, input pulse_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Signal bundle between the servo PWM generator and its user.
// There is no handshake: en and value are level inputs that the generator samples
// only in the last cycle of each frame; every output is a registered level or pulse.
interface servo_pwm_gen_if
    import servo_pkg::*;
();
    logic   en;
    pulse_t value;
    logic   pwm_out;
    logic   frame_start;
    pulse_t cur_width;
    logic   settled;
    pulse_t target;      // clamped version of value, for debug visibility

    modport slave (
        input  en, value,
        output pwm_out, frame_start, cur_width, settled, target
    );

    modport master (
        output en, value,
        input  pwm_out, frame_start, cur_width, settled, target
    );
endinterface

// File: rtl/servo_slew_limiter.sv
// Combinational width update: clamps the raw command and steps the current
// width toward it by at most step cycles (step of zero means jump directly).
module servo_slew_limiter
    import servo_pkg::*;
#(
    parameter pulse_t MIN_PULSE = SERVO_MIN,
    parameter pulse_t MAX_PULSE = SERVO_MAX
) (
    input  pulse_t cur_i,
    input  pulse_t tgt_raw_i,
    input  pulse_t step_i,
    output pulse_t tgt_o,
    output pulse_t next_width_o,
    output logic   settled_next_o
);

    logic        up;
    logic [20:0] diff;

    always_comb begin
        tgt_o = clamp_pulse(tgt_raw_i, MIN_PULSE, MAX_PULSE);
        up    = (tgt_o >= cur_i);
        // Distance is taken in the ordered direction so it can never wrap.
        diff  = up ? ({1'b0, tgt_o} - {1'b0, cur_i}) : ({1'b0, cur_i} - {1'b0, tgt_o});

        next_width_o = tgt_o;
        if ((step_i != '0) && (diff > {1'b0, step_i})) begin
            next_width_o = up ? (cur_i + step_i) : (cur_i - step_i);
        end
        settled_next_o = (next_width_o == tgt_o);
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: free-running frame counter, width updated only at the
// frame boundary, registered output so each enabled frame is exactly cur_width high.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = SERVO_PERIOD_100MHZ,
    parameter int unsigned CNT_W         = 21,
    parameter pulse_t      MIN_PULSE     = SERVO_MIN,
    parameter pulse_t      MAX_PULSE     = SERVO_MAX,
    parameter pulse_t      RESET_PULSE   = SERVO_NEUTRAL,
    parameter pulse_t      SLEW_STEP     = 20'd5000
) (
    input logic             clk,
    input logic             rst_n,
    servo_pwm_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    pulse_t           cur_width_q, cur_width_d;
    logic             settled_q, settled_d;
    logic             pwm_q, pwm_d;
    logic             frame_start_q, frame_start_d;

    pulse_t           tgt;
    pulse_t           next_width;
    logic             settled_next;
    logic             at_boundary;

    servo_slew_limiter #(
        .MIN_PULSE (MIN_PULSE),
        .MAX_PULSE (MAX_PULSE)
    ) u_slew (
        .cur_i          (cur_width_q),
        .tgt_raw_i      (bus.value),
        .step_i         (SLEW_STEP),
        .tgt_o          (tgt),
        .next_width_o   (next_width),
        .settled_next_o (settled_next)
    );

    always_comb begin
        at_boundary   = (cnt_q == CNT_LAST);
        cnt_d         = at_boundary ? '0 : cnt_q + CNT_W'(1);
        en_d          = en_q;
        cur_width_d   = cur_width_q;
        settled_d     = settled_q;
        if (at_boundary) begin
            en_d        = bus.en;
            cur_width_d = next_width;
            settled_d   = settled_next;
        end
        // Both registered from the same cnt value, so frame_start lines up with the first high cycle.
        frame_start_d = (cnt_q == '0);
        pwm_d         = en_q && (32'(cnt_q) < 32'(cur_width_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            en_q          <= 1'b0;
            cur_width_q   <= RESET_PULSE;
            settled_q     <= 1'b0;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            cur_width_q   <= cur_width_d;
            settled_q     <= settled_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.frame_start = frame_start_q;
    assign bus.cur_width   = cur_width_q;
    assign bus.settled     = settled_q;
    assign bus.target      = tgt;

endmodule
